// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: routes CPU requests to a word-addressed data RAM
// or to board IO registers (hex/LED outputs, synchronized key/switch inputs).
module mmio_bus_ctrl #(
    parameter int               DBITS        = 32,
    parameter int               DMEMADDRBITS = 13,
    parameter int               DMEMWORDBITS = 2,
    parameter logic [DBITS-1:0] ADDR_HEX     = 32'hF0000000,
    parameter logic [DBITS-1:0] ADDR_LEDR    = 32'hF0000004,
    parameter logic [DBITS-1:0] ADDR_LEDG    = 32'hF0000008,
    parameter logic [DBITS-1:0] ADDR_KEY     = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_SW      = 32'hF0000014
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    output logic             ack,
    output logic [DBITS-1:0] rdata,
    output logic [10:0]      dmem_addr,
    output logic             dmem_we,
    output logic [DBITS-1:0] dmem_wdata,
    input  logic [DBITS-1:0] dmem_rdata,
    input  logic [3:0]       key,
    input  logic [9:0]       sw,
    output logic [15:0]      hex,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg
);

    // state | meaning
    // IDLE  | waiting for req; IO/unmapped accesses complete from here
    // DMEM  | RAM address (and write strobe) presented
    // DWAIT | RAM read data arriving, captured into rdata
    // RESP  | single-cycle ack
    typedef enum logic [1:0] {IDLE, DMEM, DWAIT, RESP} state_t;

    state_t           state;
    logic             xact_we;
    logic [3:0]       key_meta;
    logic [3:0]       key_sync;
    logic [3:0]       key_prev;
    logic [9:0]       sw_meta;
    logic [9:0]       sw_sync;
    logic [3:0]       press;

    logic             is_dmem;
    logic             is_hex;
    logic             is_ledr;
    logic             is_ledg;
    logic             is_key;
    logic             is_sw;
    logic             key_rd_accept;
    logic [3:0]       key_rise;
    logic [DBITS-1:0] io_rdata;

    assign is_dmem = (addr[DBITS-1:DMEMADDRBITS] == '0);
    assign is_hex  = (addr == ADDR_HEX);
    assign is_ledr = (addr == ADDR_LEDR);
    assign is_ledg = (addr == ADDR_LEDG);
    assign is_key  = (addr == ADDR_KEY);
    assign is_sw   = (addr == ADDR_SW);

    assign key_rd_accept = (state == IDLE) && req && !we && is_key;
    // keys are active-low, so a press is a 1->0 transition of the synchronized level
    assign key_rise      = ~key_sync & key_prev;

    always_comb begin
        io_rdata = '0;
        if (is_hex)
            io_rdata = DBITS'(hex);
        else if (is_ledr)
            io_rdata = DBITS'(ledr);
        else if (is_ledg)
            io_rdata = DBITS'(ledg);
        else if (is_key)
            io_rdata = DBITS'({press, ~key_sync});
        else if (is_sw)
            io_rdata = DBITS'(sw_sync);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            xact_we    <= 1'b0;
            ack        <= 1'b0;
            rdata      <= '0;
            dmem_addr  <= '0;
            dmem_we    <= 1'b0;
            dmem_wdata <= '0;
            hex        <= '0;
            ledr       <= '0;
            ledg       <= '0;
            key_meta   <= 4'hF;
            key_sync   <= 4'hF;
            key_prev   <= 4'hF;
            sw_meta    <= '0;
            sw_sync    <= '0;
            press      <= '0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
            key_prev <= key_sync;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            // an edge landing on the clearing read wins over the clear
            press    <= (press & ~{4{key_rd_accept}}) | key_rise;

            case (state)
                IDLE: begin
                    ack     <= 1'b0;
                    dmem_we <= 1'b0;
                    if (req) begin
                        if (is_dmem) begin
                            state      <= DMEM;
                            xact_we    <= we;
                            dmem_we    <= we;
                            dmem_addr  <= addr[DMEMWORDBITS +: 11];
                            dmem_wdata <= wdata;
                        end else begin
                            state <= RESP;
                            ack   <= 1'b1;
                            if (we) begin
                                if (is_hex)
                                    hex <= wdata[15:0];
                                if (is_ledr)
                                    ledr <= wdata[9:0];
                                if (is_ledg)
                                    ledg <= wdata[7:0];
                            end else begin
                                rdata <= io_rdata;
                            end
                        end
                    end
                end
                DMEM: begin
                    dmem_we <= 1'b0;
                    if (xact_we) begin
                        ack   <= 1'b1;
                        state <= RESP;
                    end else begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    rdata <= dmem_rdata;
                    ack   <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack     <= 1'b0;
                    dmem_we <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: transactions push expected results to a
// scoreboard queue which is popped when the DUT acks.
module tb_mmio_bus_ctrl;

    localparam logic [31:0] A_HEX  = 32'hF0000000;
    localparam logic [31:0] A_LEDR = 32'hF0000004;
    localparam logic [31:0] A_LEDG = 32'hF0000008;
    localparam logic [31:0] A_KEY  = 32'hF0000010;
    localparam logic [31:0] A_SW   = 32'hF0000014;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic [10:0] dmem_addr;
    logic        dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    typedef struct {
        logic [31:0] rdata;
        bit          chk;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          we_count = 0;
    logic        fw;
    logic [10:0] fa;
    logic [31:0] mem [0:2047];

    mmio_bus_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .key        (key),
        .sw         (sw),
        .hex        (hex),
        .ledr       (ledr),
        .ledg       (ledg)
    );

    always #5 clk = ~clk;

    // synchronous RAM: data valid one cycle after the address
    always @(posedge clk) begin
        if (dmem_we === 1'b1)
            mem[dmem_addr] <= dmem_wdata;
        dmem_rdata <= mem[dmem_addr];
        if (dmem_we === 1'b1)
            we_count <= we_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input bit chk, input int lat, input bit hold);
        exp_t e;
        int   n;
        e.rdata = er;
        e.chk   = chk;
        e.lat   = lat;
        sb.push_back(e);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                fw = dmem_we;
                fa = dmem_addr;
                if (!hold)
                    req = 1'b0;
            end
        end while (ack !== 1'b1 && n < 10);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout addr=%h: no ack within %0d cycles", a, n);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (n !== e.lat) begin
                errors++;
                $display("FAIL ack_latency addr=%h: got %0d cycles, expected %0d", a, n, e.lat);
            end
            if (e.chk) begin
                checks++;
                if (rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata addr=%h: got %h, expected %h", a, rdata, e.rdata);
                end
            end
            tick();
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL ack_pulse addr=%h: ack=%b one cycle after ack, expected 0", a, ack);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 1'b1;
        we    = 1'b1;
        addr  = A_HEX;
        wdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        req   = 1'b0;
        reset = 1'b1;
        checks++;
        if ({ack, dmem_we, hex, ledr, ledg, rdata, dmem_addr, dmem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b we=%b hex=%h ledr=%h ledg=%h rdata=%h daddr=%h dwdata=%h, expected all 0",
                     ack, dmem_we, hex, ledr, ledg, rdata, dmem_addr, dmem_wdata);
        end
        repeat (3) begin
            tick();
            checks++;
            if (ack !== 1'b0 || hex !== 16'h0) begin
                errors++;
                $display("FAIL reset_req_ignored: ack=%b hex=%h, expected 0/0000", ack, hex);
            end
        end
    endtask

    task automatic test_io();
        txn(1'b1, A_HEX, 32'h0000BEEF, '0, 1'b0, 1, 1'b0);
        checks++;
        if (hex !== 16'hBEEF) begin
            errors++;
            $display("FAIL hex_write: got %h, expected beef", hex);
        end
        txn(1'b0, A_HEX, '0, 32'h0000BEEF, 1'b1, 1, 1'b0);
        txn(1'b1, A_LEDR, 32'hFFFF_F3A5, '0, 1'b0, 1, 1'b0);
        txn(1'b0, A_LEDR, '0, 32'h0000_03A5, 1'b1, 1, 1'b0);
        txn(1'b1, A_LEDG, 32'h1234_56C3, '0, 1'b0, 1, 1'b0);
        txn(1'b0, A_LEDG, '0, 32'h0000_00C3, 1'b1, 1, 1'b0);
        sw = 10'h2AB;
        repeat (3) tick();
        txn(1'b0, A_SW, '0, 32'h0000_02AB, 1'b1, 1, 1'b0);
        txn(1'b1, A_SW, 32'hFFFF_FFFF, '0, 1'b0, 1, 1'b0);
        txn(1'b1, A_KEY, 32'hFFFF_FFFF, '0, 1'b0, 1, 1'b0);
        checks++;
        if (hex !== 16'hBEEF || ledr !== 10'h3A5 || ledg !== 8'hC3) begin
            errors++;
            $display("FAIL io_regs_kept: hex=%h ledr=%h ledg=%h, expected beef/3a5/c3", hex, ledr, ledg);
        end
    endtask

    task automatic test_dmem();
        txn(1'b1, 32'h0000_0104, 32'h1234_5678, '0, 1'b0, 2, 1'b0);
        checks++;
        if (fw !== 1'b1 || fa !== 11'd65) begin
            errors++;
            $display("FAIL dmem_write_cycle: dmem_we=%b dmem_addr=%0d, expected 1/65", fw, fa);
        end
        txn(1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, '0, 1'b0, 2, 1'b0);
        txn(1'b0, 32'h0000_0107, '0, 32'h1234_5678, 1'b1, 3, 1'b0);
        checks++;
        if (fw !== 1'b0 || fa !== 11'd65) begin
            errors++;
            $display("FAIL dmem_read_cycle: dmem_we=%b dmem_addr=%0d, expected 0/65", fw, fa);
        end
        txn(1'b0, 32'h0000_1FFC, '0, 32'hCAFE_F00D, 1'b1, 3, 1'b0);
    endtask

    task automatic test_key();
        key = 4'b1110;
        repeat (3) tick();
        key = 4'hF;
        repeat (4) tick();
        txn(1'b0, A_KEY, '0, 32'h0000_0010, 1'b1, 1, 1'b0);
        txn(1'b0, A_KEY, '0, 32'h0000_0000, 1'b1, 1, 1'b0);
        key = 4'b0101;
        repeat (5) tick();
        txn(1'b0, A_KEY, '0, 32'h0000_00AA, 1'b1, 1, 1'b0);
        key = 4'hF;
        repeat (4) tick();
        txn(1'b0, A_KEY, '0, 32'h0000_0000, 1'b1, 1, 1'b0);
        // press edge lands on the same edge as the clearing read
        key = 4'b1110;
        repeat (2) tick();
        txn(1'b0, A_KEY, '0, 32'h0000_0001, 1'b1, 1, 1'b0);
        key = 4'hF;
        repeat (4) tick();
        txn(1'b0, A_KEY, '0, 32'h0000_0010, 1'b1, 1, 1'b0);
    endtask

    task automatic test_unmapped();
        int wc;
        wc = we_count;
        txn(1'b0, A_HEX, '0, 32'h0000BEEF, 1'b1, 1, 1'b0);
        repeat (3) tick();
        checks++;
        if (rdata !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL rdata_hold: got %h, expected 0000beef", rdata);
        end
        txn(1'b0, 32'h8000_0000, '0, 32'h0, 1'b1, 1, 1'b0);
        txn(1'b0, A_HEX, '0, 32'h0000BEEF, 1'b1, 1, 1'b0);
        txn(1'b0, 32'hF000_0001, '0, 32'h0, 1'b1, 1, 1'b0);
        txn(1'b1, 32'h0000_2000, 32'h5555_5555, '0, 1'b0, 1, 1'b0);
        checks++;
        if (we_count !== wc || hex !== 16'hBEEF) begin
            errors++;
            $display("FAIL unmapped_side_effect: dmem_we pulses=%0d hex=%h, expected 0/beef",
                     we_count - wc, hex);
        end
    endtask

    task automatic test_reset_mid();
        int wc;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h0000_0040;
        wdata = 32'hDEAD_0001;
        tick();
        req = 1'b0;
        checks++;
        if (dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: dmem_we=%b, expected 1", dmem_we);
        end
        reset = 1'b0;
        tick();
        wc = we_count;
        checks++;
        if ({ack, dmem_we, hex, ledr, ledg, rdata, dmem_addr, dmem_wdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: ack=%b we=%b hex=%h ledr=%h ledg=%h rdata=%h daddr=%h, expected all 0",
                     ack, dmem_we, hex, ledr, ledg, rdata, dmem_addr);
        end
        tick();
        reset = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (ack !== 1'b0 || we_count !== wc) begin
                errors++;
                $display("FAIL mid_abandon: ack=%b extra dmem_we=%0d, expected 0/0", ack, we_count - wc);
            end
        end
    endtask

    task automatic test_back_to_back();
        txn(1'b1, 32'h0000_0104, 32'h0BAD_CAFE, '0, 1'b0, 2, 1'b1);
        txn(1'b1, A_HEX, 32'h0000_A5A5, '0, 1'b0, 1, 1'b1);
        txn(1'b0, 32'h0000_0104, '0, 32'h0BAD_CAFE, 1'b1, 3, 1'b1);
        txn(1'b0, A_HEX, '0, 32'h0000_A5A5, 1'b1, 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++)
            mem[i] = '0;
        reset = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        key   = 4'hF;
        sw    = '0;
        fw    = 1'b0;
        fa    = '0;
        tick();
        test_reset();
        test_io();
        test_dmem();
        test_key();
        test_unmapped();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

Interface
REQ-001 SHALL have parameter DBITS, default 32: data/address width.
REQ-002 SHALL have parameter DMEMADDRBITS, default 13: byte-address bits decoded as data memory.
REQ-003 SHALL have parameter DMEMWORDBITS, default 2: byte-offset bits dropped from the word index.
REQ-004 SHALL have parameters ADDR_HEX/ADDR_LEDR/ADDR_LEDG/ADDR_KEY/ADDR_SW, defaults 32'hF0000000/04/08/10/14: IO register addresses.
REQ-005 SHALL have port clk, in, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, in, 1: synchronous, active-low reset; asserted when 0, sampled on clk.
REQ-007 SHALL have port req, in, 1: CPU transaction request.
REQ-008 SHALL have port we, in, 1: 1 = write, 0 = read.
REQ-009 SHALL have ports addr, in, DBITS and wdata, in, DBITS: byte address and write data.
REQ-010 SHALL have ports ack, out, 1 and rdata, out, DBITS: completion pulse and read data, both registered.
REQ-011 SHALL have ports dmem_addr, out, 11; dmem_we, out, 1; dmem_wdata, out, DBITS: registered data-RAM controls.
REQ-012 SHALL have port dmem_rdata, in, DBITS: RAM read data, valid one cycle after dmem_addr.
REQ-013 SHALL have ports key, in, 4 (active-low buttons) and sw, in, 10: asynchronous board inputs.
REQ-014 SHALL have ports hex, out, 16; ledr, out, 10; ledg, out, 8: registered board outputs.

Function
REQ-015 SHALL use FSM states IDLE, DMEM, DWAIT, RESP; req SHALL be sampled only in IDLE.
REQ-016 SHALL decode DMEM as addr[DBITS-1:DMEMADDRBITS]==0, with word index addr[12:2]; addr[1:0] SHALL be ignored.
REQ-017 SHALL decode IO only on an exact 32-bit match; any other address is unmapped.
REQ-018 IO or unmapped, accepted in cycle N: SHALL go IDLE->RESP, with ack=1 in N+1.
REQ-019 DMEM write accepted in N: SHALL drive dmem_we=1 with dmem_addr/dmem_wdata in N+1 (state DMEM), and ack in N+2.
REQ-020 DMEM read accepted in N: SHALL drive dmem_addr in N+1, wait in DWAIT at N+2, and give ack with rdata=dmem_rdata at N+3.
REQ-021 SHALL hold ack high for exactly one cycle (RESP), then return to IDLE; a req high in the next IDLE cycle starts a new transaction.
REQ-022 Requester SHALL hold addr/we/wdata stable from request until ack; the block SHALL latch them at acceptance.
REQ-023 SHALL keep dmem_we=0 in every state except DMEM on a write.
REQ-024 IO writes SHALL update at acceptance: hex<=wdata[15:0], ledr<=wdata[9:0], ledg<=wdata[7:0].
REQ-025 Writes to KEY/SW or unmapped addresses SHALL be dropped but still acked.
REQ-026 Reads of HEX/LEDR/LEDG SHALL return the current register value, zero-extended.
REQ-027 Unmapped reads SHALL return 0.
REQ-028 key and sw SHALL each pass through a 2-flop synchronizer; pressed = ~key_sync.
REQ-029 Sticky press flags press[3:0] SHALL set on the pressed rising edge (synchronized).
REQ-030 KEY read SHALL return {24'b0, press, pressed} and clear press at acceptance.
REQ-031 A new edge coinciding with the clearing read SHALL leave that flag set.
REQ-032 SW read SHALL return sw_sync zero-extended.
REQ-033 rdata SHALL hold its last value when ack=0.

Reset
REQ-034 On reset=0 at a clk edge: state=IDLE; ack, rdata, hex, ledr, ledg, dmem_we, dmem_addr, dmem_wdata, press = 0; key sync flops=4'hF; sw sync flops=0.
REQ-035 Reset mid-transaction SHALL abandon it: no ack, no dmem_we after the reset edge, and no IO register update if the write was not yet accepted.
REQ-036 req SHALL be ignored while reset=0.

Verification
REQ-037 Write 32'h0000BEEF to F0000000 -> ack at N+1; hex=16'hBEEF next cycle; a read returns 32'h0000BEEF.
REQ-038 Write 32'h12345678 to 0x00000104, then read 0x00000107 -> dmem_we=1, dmem_addr=65 at N+1; read ack at N+3 with rdata=32'h12345678.
REQ-039 key=4'b1110 held 3 cycles, then released; read F0000010 -> rdata=32'h10; second read -> 32'h00.
REQ-040 Read 0x80000000 and write 0x00002000 -> ack at N+1; rdata=0; dmem_we never asserted.
REQ-041 DMEM write accepted, reset=0 in N+1 -> dmem_we=0 and ack=0 afterwards; state=IDLE; all outputs 0.
REQ-042 Back-to-back req held high across ack -> second transaction accepted in the IDLE cycle right after RESP; each ack is a single-cycle pulse.
